// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// cycle counter width and the upper bound on the number of reset domains.
package rst_seq_pkg;

  localparam int CNT_W      = 32;
  localparam int NSTAGE_MAX = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    ST_POR     = 3'd0,
    ST_GAP     = 3'd1,
    ST_ACKWAIT = 3'd2,
    ST_RUN     = 3'd3,
    ST_SHUT    = 3'd4
  } rst_seq_state_e;

endpackage

// File: rtl/rst_seq_tmr.sv
// Loadable up-counter shared by the POR, GAP and ACKWAIT phases. done_o is
// high while the count equals the terminal value; the count holds there.
module rst_seq_tmr
  import rst_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_in,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Power-on / soft reset sequencer: holds all domains in reset for a POR
// period, then releases them one by one in ascending order, waiting for each
// domain's acknowledge (or a timeout) before moving on.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NSTAGE     = 4,
  parameter int unsigned POR_CYCLES = 1000 * 1000 * 100,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned ACK_TO     = 1024
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              soft_rst_req,
  input  logic [NSTAGE-1:0] stage_ack,
  output logic [NSTAGE-1:0] rst,
  output logic [NSTAGE-1:0] rstn,
  output logic              all_ready,
  output logic              busy,
  output logic [NSTAGE-1:0] timeout_err,
  output rst_seq_state_e    dbg_state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 1);
  localparam logic [CNT_W-1:0] POR_TERM = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_TERM = CNT_W'(ACK_TO - 1);

  rst_seq_state_e    state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NSTAGE-1:0] rst_q;
  logic [NSTAGE-1:0] tout_q;
  logic              all_ready_q;
  logic              busy_q;

  logic [NSTAGE-1:0] sel_oh;
  logic              ack_sel;
  logic              step_done;
  logic              tmr_clr;
  logic              tmr_done;
  logic [CNT_W-1:0]  tmr_term;

  // stage_ack is a level, not a handshake: only bit idx is looked at, and only
  // in ACKWAIT. A high level completes the stage at the next edge; there is no
  // ready/valid pairing and the sequencer never drives anything back on it.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      sel_oh[k] = (idx_q == IDX_W'(k));
    end
  end

  assign ack_sel = |(stage_ack & sel_oh);

  always_comb begin
    tmr_term  = POR_TERM;
    step_done = 1'b0;
    case (state_q)
      ST_POR: begin
        step_done = tmr_done;
      end
      ST_GAP: begin
        tmr_term  = GAP_TERM;
        step_done = tmr_done;
      end
      ST_ACKWAIT: begin
        tmr_term  = ACK_TERM;
        step_done = ack_sel || tmr_done;
      end
      default: begin
        tmr_term  = POR_TERM;
        step_done = 1'b0;
      end
    endcase
  end

  // Counter restarts from zero whenever a phase ends or the FSM is idle.
  assign tmr_clr = step_done || (state_q == ST_RUN) || (state_q == ST_SHUT);

  rst_seq_tmr u_tmr (
    .clk    (clk),
    .rst_in (rst_in),
    .clr_i  (tmr_clr),
    .en_i   (1'b1),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_POR;
      idx_q       <= '0;
      rst_q       <= '1;
      tout_q      <= '0;
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_POR: begin
          if (step_done) begin
            state_q <= ST_GAP;
            idx_q   <= '0;
          end
        end
        ST_GAP: begin
          if (step_done) begin
            rst_q   <= rst_q & ~sel_oh;
            state_q <= ST_ACKWAIT;
          end
        end
        ST_ACKWAIT: begin
          if (step_done) begin
            if (!ack_sel) begin
              tout_q <= tout_q | sel_oh;
            end
            if (idx_q == LAST_IDX) begin
              state_q     <= ST_RUN;
              all_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_GAP;
            end
          end
        end
        ST_RUN: begin
          if (soft_rst_req) begin
            state_q     <= ST_SHUT;
            idx_q       <= LAST_IDX;
            all_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_SHUT: begin
          // Re-assert top-down, one domain per cycle, then re-release without POR.
          rst_q <= rst_q | sel_oh;
          if (idx_q == '0) begin
            state_q <= ST_GAP;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: begin
          state_q <= ST_POR;
        end
      endcase
    end
  end

  assign rst         = rst_q;
  assign rstn        = ~rst_q;
  assign all_ready   = all_ready_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a 4-stage instance and a 1-stage instance with
// short POR/GAP/ACK timing, checked against hand-computed release edges.
module tb_rst_seq;
  import rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [3:0] stage_ack = 4'hF;
  logic [3:0] rst, rstn, timeout_err;
  logic       all_ready, busy;
  rst_seq_state_e dbg_state;

  logic       soft1 = 1'b0;
  logic [0:0] ack1 = 1'b1;
  logic [0:0] rst1, rstn1, tout1;
  logic       all_ready1, busy1;
  rst_seq_state_e dbg_state1;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = -1;
  int rise_e[4];
  int fall_e[4];
  int ar_e;
  int order_bad = 0;
  int inv_bad   = 0;
  bit noise_en  = 1'b0;

  rst_seq #(.NSTAGE(4), .POR_CYCLES(20), .GAP_CYCLES(4), .ACK_TO(8)) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .soft_rst_req (soft_rst_req),
    .stage_ack    (stage_ack),
    .rst          (rst),
    .rstn         (rstn),
    .all_ready    (all_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .dbg_state_o  (dbg_state)
  );

  rst_seq #(.NSTAGE(1), .POR_CYCLES(20), .GAP_CYCLES(4), .ACK_TO(8)) dut1 (
    .clk          (clk),
    .rst_in       (rst_in),
    .soft_rst_req (soft1),
    .stage_ack    (ack1),
    .rst          (rst1),
    .rstn         (rstn1),
    .all_ready    (all_ready1),
    .busy         (busy1),
    .timeout_err  (tout1),
    .dbg_state_o  (dbg_state1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b1;
    #2;
    check("rst_val",     32'(rst), 32'hF);
    check("rstn_val",    32'(rstn), 32'h0);
    check("ready_rst",   32'(all_ready), 32'd0);
    check("busy_rst",    32'(busy), 32'd1);
    check("tout_rst",    32'(timeout_err), 32'h0);
    check("state_rst",   32'(dbg_state), 32'(ST_POR));
    @(negedge clk);
    rst_in = 1'b0;
    edge_n = -1;
  endtask

  task automatic soft_pulse();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
  endtask

  // Records rise/fall edges of each rst bit and the all_ready rise, relative to base.
  task automatic monitor(input int base, input int n);
    logic [3:0] prev, nr;
    logic       prev_ar;
    for (int k = 0; k < 4; k++) begin
      rise_e[k] = -1;
      fall_e[k] = -1;
    end
    ar_e    = -1;
    prev    = rst;
    prev_ar = all_ready;
    for (int i = 0; i < n; i++) begin
      soft_rst_req = noise_en && (edge_n + 1 == 10 || edge_n + 1 == 22 ||
                                  edge_n + 1 == 25 || edge_n + 1 == 27 ||
                                  edge_n + 1 == 35);
      tick();
      soft_rst_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (rst[k] && !prev[k] && rise_e[k] < 0) rise_e[k] = edge_n - base;
        if (!rst[k] && prev[k] && fall_e[k] < 0) fall_e[k] = edge_n - base;
      end
      if (all_ready && !prev_ar && ar_e < 0) ar_e = edge_n - base;
      if (rstn !== ~rst) inv_bad++;
      nr = ~rst;
      if ((nr & (nr + 4'd1)) != 4'd0) order_bad++;
      prev    = rst;
      prev_ar = all_ready;
    end
  endtask

  initial begin
    int base;

    // Power-on sequence, all acks high
    stage_ack = 4'hF;
    do_reset();
    monitor(0, 60);
    check("por_fall0", 32'(fall_e[0]), 32'd24);
    check("por_fall1", 32'(fall_e[1]), 32'd29);
    check("por_fall2", 32'(fall_e[2]), 32'd34);
    check("por_fall3", 32'(fall_e[3]), 32'd39);
    check("por_ready", 32'(ar_e), 32'd40);
    check("por_busy",  32'(busy), 32'd0);
    check("por_tout",  32'(timeout_err), 32'h0);
    check("por_state", 32'(dbg_state), 32'(ST_RUN));

    // Soft reset from RUN
    soft_pulse();
    base = edge_n;
    check("soft_ready_drop", 32'(all_ready), 32'd0);
    check("soft_busy",       32'(busy), 32'd1);
    check("soft_state",      32'(dbg_state), 32'(ST_SHUT));
    monitor(base, 40);
    check("soft_rise3", 32'(rise_e[3]), 32'd1);
    check("soft_rise2", 32'(rise_e[2]), 32'd2);
    check("soft_rise1", 32'(rise_e[1]), 32'd3);
    check("soft_rise0", 32'(rise_e[0]), 32'd4);
    check("soft_fall0", 32'(fall_e[0]), 32'd8);
    check("soft_fall1", 32'(fall_e[1]), 32'd13);
    check("soft_fall2", 32'(fall_e[2]), 32'd18);
    check("soft_fall3", 32'(fall_e[3]), 32'd23);
    check("soft_ready", 32'(ar_e), 32'd24);

    // Stage 2 never acknowledges: timeout after 8 ACKWAIT cycles
    stage_ack = 4'b1011;
    do_reset();
    monitor(0, 70);
    check("to_fall2", 32'(fall_e[2]), 32'd34);
    check("to_fall3", 32'(fall_e[3]), 32'd46);
    check("to_ready", 32'(ar_e), 32'd47);
    check("to_err",   32'(timeout_err), 32'b0100);

    // Soft reset keeps the sticky timeout flag
    soft_pulse();
    base = edge_n;
    monitor(base, 50);
    check("to_soft_fall3", 32'(fall_e[3]), 32'd30);
    check("to_soft_ready", 32'(ar_e), 32'd31);
    check("to_soft_err",   32'(timeout_err), 32'b0100);

    // Soft requests outside RUN must not disturb timing
    stage_ack = 4'hF;
    do_reset();
    noise_en = 1'b1;
    monitor(0, 60);
    noise_en = 1'b0;
    check("noise_fall0", 32'(fall_e[0]), 32'd24);
    check("noise_fall1", 32'(fall_e[1]), 32'd29);
    check("noise_fall2", 32'(fall_e[2]), 32'd34);
    check("noise_fall3", 32'(fall_e[3]), 32'd39);
    check("noise_ready", 32'(ar_e), 32'd40);

    // rst_in while stage 2 waits for its ack
    stage_ack = 4'b1011;
    do_reset();
    for (int i = 0; i < 37; i++) tick();
    check("mid_state", 32'(dbg_state), 32'(ST_ACKWAIT));
    check("mid_rst",   32'(rst), 32'b1000);
    rst_in = 1'b1;
    #1;
    check("mid_async_rst",   32'(rst), 32'hF);
    check("mid_async_rstn",  32'(rstn), 32'h0);
    check("mid_async_state", 32'(dbg_state), 32'(ST_POR));
    check("mid_async_busy",  32'(busy), 32'd1);
    #1;
    rst_in = 1'b0;
    edge_n = -1;
    monitor(0, 30);
    check("mid_fall0", 32'(fall_e[0]), 32'd24);
    check("mid_tout",  32'(timeout_err), 32'h0);

    // Single-stage instance: soft reset cycle
    stage_ack = 4'hF;
    do_reset();
    for (int i = 0; i < 31; i++) tick();
    check("one_ready", 32'(all_ready1), 32'd1);
    check("one_rst",   32'(rst1), 32'd0);
    soft1 = 1'b1;
    tick();
    soft1 = 1'b0;
    base = edge_n;
    check("one_ready_drop", 32'(all_ready1), 32'd0);
    begin
      int r1, f1, a1;
      r1 = -1; f1 = -1; a1 = -1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (rst1[0] && r1 < 0) r1 = edge_n - base;
        if (!rst1[0] && r1 >= 0 && f1 < 0) f1 = edge_n - base;
        if (all_ready1 && a1 < 0) a1 = edge_n - base;
      end
      check("one_rise",  32'(r1), 32'd1);
      check("one_fall",  32'(f1), 32'd5);
      check("one_ready_back", 32'(a1), 32'd6);
    end
    check("one_tout", 32'(tout1), 32'd0);

    check("order_viol", 32'(order_bad), 32'd0);
    check("rstn_viol",  32'(inv_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL provide parameter NSTAGE, default 4: number of reset domains sequenced, legal range 1..8.
REQ-002 SHALL provide parameter POR_CYCLES, default 1000*1000*100: power-on hold time in clk cycles.
REQ-003 SHALL provide parameter GAP_CYCLES, default 16: delay in clk cycles before each stage release.
REQ-004 SHALL provide parameter ACK_TO, default 1024: per-stage acknowledge timeout in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port soft_rst_req, input, 1 bit: single-cycle request, e.g. from the UART command decoder, to re-sequence all domains.
REQ-008 SHALL have port stage_ack, input, NSTAGE bits: bit k high means domain k is up after its release.
REQ-009 SHALL have port rst, output, NSTAGE bits: active-high reset per domain.
REQ-010 SHALL have port rstn, output, NSTAGE bits: always the bitwise inverse of rst.
REQ-011 SHALL have port all_ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except RUN.
REQ-013 SHALL have port timeout_err, output, NSTAGE bits: sticky flag per stage.

Function
REQ-014 SHALL implement states POR, GAP, ACKWAIT, RUN and SHUT, with one 32-bit cycle counter and a stage index idx.
REQ-015 In POR, SHALL count POR_CYCLES cycles, then enter GAP with idx=0 and counter=0.
REQ-016 In GAP, SHALL count GAP_CYCLES cycles, then clear rst[idx] (registered) and enter ACKWAIT with counter=0.
REQ-017 In ACKWAIT, SHALL sample stage_ack[idx] from the first cycle onward; an ack already high on entry SHALL complete the stage after one cycle.
REQ-018 In ACKWAIT, when the counter reaches ACK_TO-1 without an ack, SHALL set timeout_err[idx] and proceed as if acknowledged.
REQ-019 On completion of a stage, SHALL go to GAP with idx+1 if idx<NSTAGE-1, otherwise to RUN.
REQ-020 SHALL ignore stage_ack bits other than stage_ack[idx] in all states, and SHALL ignore all stage_ack bits in POR, GAP, RUN and SHUT.
REQ-021 In RUN, soft_rst_req SHALL cause entry to SHUT with idx=NSTAGE-1.
REQ-022 soft_rst_req SHALL be ignored in every state except RUN.
REQ-023 In SHUT, SHALL assert rst[idx], one stage per cycle in descending order; after rst[0] is asserted, SHALL enter GAP with idx=0, skipping POR.
REQ-024 Timing: with rst_in released before clk edge 0, rst[0] SHALL fall at edge POR_CYCLES+GAP_CYCLES.
REQ-025 Timing: each subsequent stage SHALL fall GAP_CYCLES+A+1 edges after the previous one, where A is the number of ACKWAIT cycles spent on the previous stage.
REQ-026 all_ready SHALL rise on the edge after the last stage completes.
REQ-027 SHALL never release stage k while any stage j<k is still in reset.
REQ-028 NSTAGE=1 SHALL be supported: in SHUT, a single-cycle assertion followed by GAP.

Reset
REQ-029 rst_in high SHALL immediately and asynchronously set rst to all ones, rstn to all zeros, all_ready=0, busy=1, timeout_err=0, counter=0, idx=0 and state=POR.
REQ-030 rst_in asserted mid-sequence, including during SHUT or ACKWAIT, SHALL restart the full POR hold.
REQ-031 timeout_err SHALL be cleared only by rst_in; soft reset SHALL NOT clear it.

Structure
REQ-032 Package rst_seq_pkg SHALL hold the state enum, the counter width constant (32) and the NSTAGE upper bound (8).
REQ-033 Sub-module rst_seq_tmr SHALL provide the loadable cycle counter, with inputs clear/enable/terminal value and a done output, shared by POR, GAP and ACKWAIT.

Verification
REQ-034 With POR_CYCLES=20, GAP=4, NSTAGE=4 and stage_ack tied high: rst[0..3] SHALL fall at edges 24, 29, 34 and 39, and all_ready SHALL rise at edge 40.
REQ-035 With stage_ack[2] held low and ACK_TO=8: timeout_err SHALL equal 4'b0100 and sequencing SHALL continue to RUN.
REQ-036 A soft_rst_req pulse in RUN SHALL assert rst[3], rst[2], rst[1], rst[0] on consecutive cycles, then re-release the stages with GAP spacing and no POR hold.
REQ-037 A soft_rst_req pulse during GAP or ACKWAIT SHALL have no effect on the sequence timing.
REQ-038 rst_in pulsed while stage 2 is in ACKWAIT SHALL immediately set rst to 4'b1111, and rst[0] SHALL fall 24 edges after rst_in release.
REQ-039 With NSTAGE=1 and a soft reset issued in RUN: rst SHALL be high for one cycle, then fall after GAP_CYCLES+1 edges.
